flash_spi_reader: RTL
=====================

Name: flash_spi_reader

Overview:
- Read-only OBI subordinate that serves the user-domain flash window, decoded at UserBaseAddr + 0x0000_0000 with a 16 MiB (24-bit) range.
- Downstream of the user-domain address demux: it consumes the OBI requests routed to the flash index.
- Each 32-bit word read is translated into one SPI mode-0 READ transaction (command 0x03, 24-bit address, 4 data bytes) on an external serial NOR flash.
- Single outstanding transaction; writes are rejected with an error response.

Parameters:
- ClkDiv, 2, SCK half-period in clk_i cycles; legal range 1..255.
- ReadCmd, 8'h03, SPI command byte sent in normal mode.
- IdWidth, 1, width of the OBI transaction ID.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant.
- addr_i  in  32  byte address; only [23:0] is used.
- we_i  in  1  write enable.
- be_i  in  4  byte enables; ignored.
- wdata_i  in  32  write data; ignored.
- aid_i  in  IdWidth  request ID.
- rvalid_o  out  1  response valid, single-cycle pulse.
- rdata_o  out  32  read data.
- err_o  out  1  error flag, qualified by rvalid_o.
- rid_o  out  IdWidth  response ID; equals the aid_i captured at grant.
- sck_o  out  1  SPI clock; idles low (mode 0).
- csn_o  out  1  SPI chip select, active-low.
- mosi_o  out  1  SPI data to flash.
- miso_i  in  1  SPI data from flash.

Behaviour:
- Reset values:
  - csn_o=1, sck_o=0, mosi_o=0.
  - gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, rid_o=0.
  - State = IDLE, all counters 0.
- gnt_o = req_i && (state==IDLE), combinational. Address, we_i and aid_i are captured on the grant cycle T0.
- States: IDLE, SHIFT, CSHOLD, RESP, ERR.
  - IDLE, granted read: go to SHIFT. Load the shift register with {ReadCmd, addr_i[23:2], 2'b00}; flash addresses are word-aligned and addr_i[1:0] is ignored.
  - IDLE, granted write: go to ERR. No SPI activity.
  - ERR: one cycle with rvalid_o=1, err_o=1, rdata_o=0, then IDLE.
  - SHIFT: csn_o=0 from T0+1. Each of the 64 bits (32 out, then 32 in) takes 2*ClkDiv cycles:
    - low phase of ClkDiv cycles, with mosi_o updated at phase start, MSB first;
    - high phase of ClkDiv cycles, with miso_i sampled on the first cycle of the high phase.
  - During the 32 data bits, mosi_o=0.
  - After the last high phase, go to CSHOLD with sck_o=0.
  - CSHOLD: one cycle with csn_o=1, then RESP.
  - RESP: rvalid_o=1, err_o=0, rdata_o = assembled word, then IDLE.
- Timing: csn_o rises at T0+1+128*ClkDiv; rvalid_o is asserted at T0+2+128*ClkDiv.
- Byte order (little-endian): the first received byte goes to rdata_o[7:0], the fourth to [31:24]. Bits within a byte arrive MSB first.
- A new grant is possible only in IDLE. It can occur in the cycle after RESP or ERR.
- req_i held high during busy states: gnt_o stays 0 and the request is not lost.
- Bit counter is 7 bits and counts 0..63; it never wraps mid-transaction. The divider counter reloads at each phase boundary.
- Reset asserted mid-transaction:
  - csn_o goes 1 and sck_o goes 0 immediately (asynchronously).
  - No response is produced for the aborted request.

Optional Feature:
- Macro: FLASH_FAST_READ_EN.
- Defined:
  - Command byte is 0x0B (FAST READ), replacing ReadCmd.
  - 8 dummy bits are inserted after the address, with mosi_o=0 and miso_i not captured.
  - Total 72 bits; rvalid_o at T0+2+144*ClkDiv.
- Undefined: behaviour as above, 64 bits using ReadCmd.

Test Plan:
- Reset values: assert rst_i mid-idle -> all outputs at reset values; csn_o=1, sck_o=0.
- Basic read: ClkDiv=2, read at UserBaseAddr+0x0012_3456; flash model returns bytes 0xEF,0xBE,0xAD,0xDE ->
  - mosi_o carries 0x03 then 0x123454;
  - rdata_o=0xDEADBEEF, err_o=0, rid_o equals aid_i;
  - rvalid_o exactly 258 cycles after the grant.
- Write rejection: write to 0x0000_0010 -> gnt_o same cycle, rvalid_o next cycle with err_o=1 and rdata_o=0; csn_o stays 1 throughout.
- Back-to-back reads: req_i held high for two reads at 0x0 and 0x4 ->
  - second gnt_o only after the first rvalid_o;
  - csn_o high for at least one cycle between the transactions;
  - both data words correct.
- Reset during transfer: assert rst_i at the 40th SCK edge -> csn_o=1 and sck_o=0 that cycle; no rvalid_o; a following read completes normally.
- Fast read (FLASH_FAST_READ_EN, ClkDiv=1): read at 0x0 -> mosi_o carries 0x0B, address, then 8 dummy zeros; rvalid_o at T0+146.

Source files
------------

// File: rtl/flash_spi_reader.sv
// flash_spi_reader: read-only OBI subordinate that turns each word read into one SPI mode-0 READ on a serial NOR flash.
// Latency: rvalid_o 2+128*ClkDiv cycles after grant (2+144*ClkDiv with FLASH_FAST_READ_EN); write errors answer the next cycle.
// Backpressure: one transaction in flight; gnt_o is low outside IDLE and a held req_i waits. FLASH_FAST_READ_EN selects FAST READ (0x0B + 8 dummy bits).
module flash_spi_reader #(
  parameter int unsigned ClkDiv  = 2,
  parameter logic [7:0]  ReadCmd = 8'h03,
  parameter int unsigned IdWidth = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        wdata_i,
  input  logic [IdWidth-1:0] aid_i,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic               err_o,
  output logic [IdWidth-1:0] rid_o,
  output logic               sck_o,
  output logic               csn_o,
  output logic               mosi_o,
  input  logic               miso_i
);

`ifdef FLASH_FAST_READ_EN
  // FAST READ: command, 24-bit address, 8 dummy bits, then 32 data bits.
  localparam logic [7:0] CmdByte = 8'h0B;
  localparam logic [6:0] LastBit = 7'd71;
  localparam logic [6:0] RxFirst = 7'd40;
`else
  // Normal READ: command, 24-bit address, then 32 data bits.
  localparam logic [7:0] CmdByte = ReadCmd;
  localparam logic [6:0] LastBit = 7'd63;
  localparam logic [6:0] RxFirst = 7'd32;
`endif

  // Bits 0..31 carry command and address; mosi_o is held low afterwards.
  localparam logic [6:0] TxLast  = 7'd31;
  // Each SCK phase lasts ClkDiv cycles; the divider counts 0..DivLast.
  localparam logic [7:0] DivLast = 8'(ClkDiv - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CSHOLD,
    RESP,
    ERR
  } state_t;

  state_t      state;
  logic [7:0]  div_cnt;
  logic [6:0]  bit_cnt;
  logic        phase_hi;
  logic [31:0] tx_sr;
  logic [31:0] rx_sr;

  // Byte enables, write data and the address bits outside the word-aligned 16 MiB window carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{be_i, wdata_i, addr_i[31:24], addr_i[1:0], ReadCmd};

  // Grant only from IDLE; held low while reset is asserted.
  assign gnt_o = req_i && (state == IDLE) && !rst_i;

  // Transaction FSM: OBI capture, SPI bit engine and response generation, all outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      phase_hi <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      csn_o    <= 1'b1;
      sck_o    <= 1'b0;
      mosi_o   <= 1'b0;
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
      rid_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            rid_o <= aid_i;
            if (we_i) begin
              // Writes never touch the SPI bus; answer with an error next cycle.
              state    <= ERR;
              rvalid_o <= 1'b1;
              err_o    <= 1'b1;
              rdata_o  <= '0;
            end else begin
              // The first bit (command MSB) goes out immediately; the rest of
              // command+address waits in tx_sr, MSB at the top.
              state    <= SHIFT;
              csn_o    <= 1'b0;
              sck_o    <= 1'b0;
              mosi_o   <= CmdByte[7];
              tx_sr    <= {CmdByte[6:0], addr_i[23:2], 2'b00, 1'b0};
              rx_sr    <= '0;
              bit_cnt  <= '0;
              div_cnt  <= '0;
              phase_hi <= 1'b0;
            end
          end
        end

        SHIFT: begin
          // The flash drives miso_i on the falling edge; capture it in the
          // first cycle of the high phase of each data bit.
          if (phase_hi && (div_cnt == '0) && (bit_cnt >= RxFirst)) begin
            rx_sr <= {rx_sr[30:0], miso_i};
          end

          if (div_cnt == DivLast) begin
            div_cnt <= '0;
            if (!phase_hi) begin
              phase_hi <= 1'b1;
              sck_o    <= 1'b1;
            end else if (bit_cnt == LastBit) begin
              // Last high phase done: park SCK low and release chip select.
              phase_hi <= 1'b0;
              sck_o    <= 1'b0;
              csn_o    <= 1'b1;
              mosi_o   <= 1'b0;
              state    <= CSHOLD;
            end else begin
              phase_hi <= 1'b0;
              sck_o    <= 1'b0;
              bit_cnt  <= bit_cnt + 7'd1;
              if (bit_cnt < TxLast) begin
                mosi_o <= tx_sr[31];
                tx_sr  <= {tx_sr[30:0], 1'b0};
              end else begin
                mosi_o <= 1'b0;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        CSHOLD: begin
          // First received byte sits in rx_sr[31:24]; it belongs in rdata_o[7:0].
          state    <= RESP;
          rvalid_o <= 1'b1;
          err_o    <= 1'b0;
          rdata_o  <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
        end

        RESP: begin
          state    <= IDLE;
          rvalid_o <= 1'b0;
        end

        ERR: begin
          state    <= IDLE;
          rvalid_o <= 1'b0;
          err_o    <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          rvalid_o <= 1'b0;
          err_o    <= 1'b0;
          csn_o    <= 1'b1;
          sck_o    <= 1'b0;
          mosi_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule
